// File: rtl/dmem_access_ctrl_if.sv
// Request/response bus between the MEM-stage access controller and a
// variable-latency data memory.
interface dmem_access_ctrl_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_rdata, dm_ready
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_rdata, dm_ready
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: runs the req/ready handshake,
// formats store lanes and load extension, and stalls the pipeline while busy.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [2:0]                 funct3,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    dmem_access_ctrl_if.master         dm,
    output logic                       stall,
    output logic                       bubble,
    output logic [31:0]                rdata_out,
    output logic                       access_err,
    output logic                       timeout_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  count, count_next;
    logic [31:0] rdata_q, rdata_next;
    logic [2:0]  f3_q, f3_next;
    logic [1:0]  off_q, off_next;
    logic        req_next, we_next;
    logic [31:0] addr_next, wdata_next;
    logic [3:0]  be_next;
    logic        access_err_next, timeout_err_next;
    logic        stall_c;
    logic        legal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'b0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'b0, h};
            default: return w;
        endcase
    endfunction

    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        legal = 1'b0;
        if (mem_read && mem_write) begin
            legal = 1'b0;
        end else if (mem_read) begin
            case (funct3)
                3'b000, 3'b100: legal = 1'b1;
                3'b001, 3'b101: legal = !addr[0];
                3'b010:         legal = (addr[1:0] == 2'b00);
                default:        legal = 1'b0;
            endcase
        end else if (mem_write) begin
            case (funct3)
                3'b000:  legal = 1'b1;
                3'b001:  legal = !addr[0];
                3'b010:  legal = (addr[1:0] == 2'b00);
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << addr[1:0];
                st_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next       = state;
        count_next       = count;
        rdata_next       = rdata_q;
        f3_next          = f3_q;
        off_next         = off_q;
        req_next         = dm.dm_req;
        we_next          = dm.dm_we;
        addr_next        = dm.dm_addr;
        be_next          = dm.dm_be;
        wdata_next       = dm.dm_wdata;
        access_err_next  = 1'b0;
        timeout_err_next = 1'b0;
        stall_c          = 1'b0;

        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (legal) begin
                        stall_c    = 1'b1;
                        state_next = ACCESS;
                        count_next = '0;
                        req_next   = 1'b1;
                        we_next    = mem_write;
                        addr_next  = {addr[31:2], 2'b00};
                        be_next    = st_be;
                        wdata_next = st_wdata;
                        f3_next    = funct3;
                        off_next   = addr[1:0];
                    end else begin
                        access_err_next = 1'b1;
                    end
                end
            end
            ACCESS: begin
                stall_c = 1'b1;
                if (dm.dm_ready) begin
                    rdata_next = dm.dm_we ? 32'h0 : fmt_load(f3_q, off_q, dm.dm_rdata);
                    count_next = '0;
                    req_next   = 1'b0;
                    state_next = DONE;
                end else if (count == LAST_COUNT) begin
                    rdata_next       = 32'h0;
                    count_next       = '0;
                    req_next         = 1'b0;
                    timeout_err_next = 1'b1;
                    state_next       = DONE;
                end else begin
                    count_next = count + 8'd1;
                end
            end
            // Release the stall for one cycle so MEM/WB takes the held
            // instruction, then rearm without retriggering on it.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the asynchronous reset clears all of it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            rdata_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            dm.dm_addr  <= '0;
            dm.dm_be    <= '0;
            dm.dm_wdata <= '0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            rdata_q     <= rdata_next;
            f3_q        <= f3_next;
            off_q       <= off_next;
            dm.dm_req   <= req_next;
            dm.dm_we    <= we_next;
            dm.dm_addr  <= addr_next;
            dm.dm_be    <= be_next;
            dm.dm_wdata <= wdata_next;
            access_err  <= access_err_next;
            timeout_err <= timeout_err_next;
        end
    end

    // Gated by reset so a held request cannot keep the pipeline frozen.
    assign stall     = reset_n & stall_c;
    assign bubble    = stall;
    assign rdata_out = (state == DONE) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed self-checking bench for dmem_access_ctrl (built with TIMEOUT=4).
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        stall, bubble, access_err, timeout_err;
    logic [31:0] rdata_out;

    int checks = 0;
    int failures = 0;

    dmem_access_ctrl_if dm_bus ();

    dmem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .dm          (dm_bus.master),
        .stall       (stall),
        .bubble      (bubble),
        .rdata_out   (rdata_out),
        .access_err  (access_err),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request, answers dm_ready in ACCESS cycle lat (0 = never),
    // and returns what was seen up to and including the DONE cycle.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int lat, input logic [31:0] rdat,
                              output int stalls, output int bubbles, output int acc,
                              output logic [31:0] addr_o, output logic [3:0] be_o,
                              output logic [31:0] wd_o, output logic we_o,
                              output logic [31:0] rout, output logic te);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        stalls    = 0;
        bubbles   = 0;
        acc       = 0;
        addr_o    = '0;
        be_o      = '0;
        wd_o      = '0;
        we_o      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bubble) bubbles++;
            if (!stall) break;
            stalls++;
            if (dm_bus.dm_req) begin
                acc++;
                addr_o = dm_bus.dm_addr;
                be_o   = dm_bus.dm_be;
                wd_o   = dm_bus.dm_wdata;
                we_o   = dm_bus.dm_we;
                dm_bus.dm_ready = (acc == lat);
                dm_bus.dm_rdata = (acc == lat) ? rdat : 32'h5A5A_5A5A;
            end
            @(posedge clk);
            #1;
            dm_bus.dm_ready = 1'b0;
        end
        rout      = rdata_out;
        te        = timeout_err;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    int          n_stall, n_bub, n_acc;
    logic [31:0] o_addr, o_wd, o_rout;
    logic [3:0]  o_be;
    logic        o_we, o_te;

    typedef struct {
        string       tag;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] exp;
    } load_vec_t;

    load_vec_t loads [3];

    initial begin
        dm_bus.dm_ready = 1'b0;
        dm_bus.dm_rdata = 32'h0;

        #12;
        check("rst_dm_req", {31'b0, dm_bus.dm_req}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_rdata_out", rdata_out, 32'h0);
        check("rst_errs", {30'b0, access_err, timeout_err}, 32'h0);
        check("rst_dm_be", {28'b0, dm_bus.dm_be}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // LW, single-cycle memory
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1, 32'hDEAD_BEEF,
                   n_stall, n_bub, n_acc, o_addr, o_be, o_wd, o_we, o_rout, o_te);
        check("lw_stall_cycles", n_stall, 2);
        check("lw_bubble_cycles", n_bub, 2);
        check("lw_dm_addr", o_addr, 32'h100);
        check("lw_dm_be", {28'b0, o_be}, 32'hF);
        check("lw_dm_we", {31'b0, o_we}, 32'h0);
        check("lw_rdata_out", o_rout, 32'hDEAD_BEEF);
        check("lw_done_dm_req", {31'b0, dm_bus.dm_req}, 32'h0);
        step();
        check("lw_idle_stall", {31'b0, stall}, 32'h0);
        check("lw_idle_rdata_out", rdata_out, 32'h0);

        // Sub-word loads from the same memory word
        loads[0] = '{"lb_103",  3'b000, 32'h103, 32'hFFFF_FF80};
        loads[1] = '{"lbu_103", 3'b100, 32'h103, 32'h0000_0080};
        loads[2] = '{"lhu_102", 3'b101, 32'h102, 32'h0000_80FF};
        foreach (loads[k]) begin
            run_access(1'b1, 1'b0, loads[k].f3, loads[k].a, 32'h0, 1, 32'h80FF_0000,
                       n_stall, n_bub, n_acc, o_addr, o_be, o_wd, o_we, o_rout, o_te);
            check({loads[k].tag, "_rdata"}, o_rout, loads[k].exp);
            check({loads[k].tag, "_addr"}, o_addr, 32'h100);
            step();
        end

        // SH, 3-cycle memory
        run_access(1'b0, 1'b1, 3'b001, 32'h206, 32'h1234_ABCD, 3, 32'hFFFF_FFFF,
                   n_stall, n_bub, n_acc, o_addr, o_be, o_wd, o_we, o_rout, o_te);
        check("sh_stall_cycles", n_stall, 4);
        check("sh_dm_be", {28'b0, o_be}, 32'hC);
        check("sh_dm_wdata", o_wd, 32'hABCD_ABCD);
        check("sh_dm_we", {31'b0, o_we}, 32'h1);
        check("sh_dm_addr", o_addr, 32'h204);
        check("sh_rdata_out", o_rout, 32'h0);
        check("sh_timeout_err", {31'b0, o_te}, 32'h0);
        step();

        // Illegal requests: misaligned LW, read+write, undefined load funct3
        for (int k = 0; k < 3; k++) begin
            mem_read  = 1'b1;
            mem_write = (k == 1);
            funct3    = (k == 2) ? 3'b011 : 3'b010;
            addr      = (k == 0) ? 32'h101 : 32'h100;
            #1;
            check($sformatf("illegal%0d_stall", k), {31'b0, stall}, 32'h0);
            step();
            mem_read  = 1'b0;
            mem_write = 1'b0;
            check($sformatf("illegal%0d_err", k), {31'b0, access_err}, 32'h1);
            check($sformatf("illegal%0d_dm_req", k), {31'b0, dm_bus.dm_req}, 32'h0);
            step();
            check($sformatf("illegal%0d_err_drop", k), {31'b0, access_err}, 32'h0);
        end

        // Timeout with dm_ready never asserted
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'h0,
                   n_stall, n_bub, n_acc, o_addr, o_be, o_wd, o_we, o_rout, o_te);
        check("to_req_cycles", n_acc, 4);
        check("to_stall_cycles", n_stall, 5);
        check("to_err", {31'b0, o_te}, 32'h1);
        check("to_rdata_out", o_rout, 32'h0);
        step();
        check("to_err_drop", {31'b0, timeout_err}, 32'h0);
        check("to_idle_stall", {31'b0, stall}, 32'h0);

        // Asynchronous reset in the second ACCESS cycle
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h400;
        step();
        step();
        check("rst_mid_req_before", {31'b0, dm_bus.dm_req}, 32'h1);
        dm_bus.dm_ready = 1'b1;
        dm_bus.dm_rdata = 32'h1111_2222;
        reset_n = 1'b0;
        #1;
        check("rst_mid_dm_req", {31'b0, dm_bus.dm_req}, 32'h0);
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        mem_read        = 1'b0;
        dm_bus.dm_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("rst_after_rdata_out", rdata_out, 32'h0);

        // Fresh SW completes normally
        run_access(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 2, 32'h0,
                   n_stall, n_bub, n_acc, o_addr, o_be, o_wd, o_we, o_rout, o_te);
        check("sw_stall_cycles", n_stall, 3);
        check("sw_dm_be", {28'b0, o_be}, 32'hF);
        check("sw_dm_wdata", o_wd, 32'hCAFE_F00D);
        check("sw_dm_addr", o_addr, 32'h40);
        check("sw_rdata_out", o_rout, 32'h0);
        step();
        check("sw_idle_stall", {31'b0, stall}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

MEM-stage data-memory access controller for the 5-stage RV32I pipeline. It takes the load/store request held in the EX/MEM register and runs a req/ready handshake with a variable-latency data memory. It formats store byte-enables and data and sign/zero-extends load data by funct3. While an access is in flight it freezes the upstream pipeline and injects bubbles into MEM/WB.

## Interface
Parameters:
- TIMEOUT, 255: maximum ACCESS cycles waiting for dm_ready before abort; range 1..255; counter is 8 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  load in MEM stage (from EX/MEM)
- mem_write  in  1  store in MEM stage
- funct3  in  3  RV32I width/sign code
- addr  in  32  byte address (ALU result)
- wdata  in  32  store source (rs2)
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = write, registered
- dm_addr  out  32  {addr[31:2],2'b00}, registered
- dm_be  out  4  byte enables, registered
- dm_wdata  out  32  lane-replicated store data, registered
- dm_rdata  in  32  memory read word
- dm_ready  in  1  memory completes access this cycle
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- bubble  out  1  forces RegWrite low into MEM/WB; equals stall
- rdata_out  out  32  formatted load data to MEM/WB ReadMemData input
- access_err  out  1  one-cycle pulse: misaligned or illegal access, or mem_read and mem_write both high
- timeout_err  out  1  one-cycle pulse: TIMEOUT reached

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset: state IDLE, all registered outputs 0, counter 0, rdata_q 0.
- IDLE, no request (mem_read=mem_write=0): stay in IDLE; stall=0.
- IDLE, legal request: stall=1 combinationally. Next edge: ACCESS, dm_req=1, and dm_we/dm_addr/dm_be/dm_wdata are loaded.
- IDLE, illegal request: no dm_req, stall=0, state stays IDLE; access_err=1 next cycle. Illegal means:
  - funct3 not in {000,001,010,100,101} for a load, or not in {000,001,010} for a store;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - mem_read and mem_write both high.
- ACCESS: stall=1; dm_* outputs held stable; counter increments each cycle.
  - dm_ready=1: capture the formatted load into rdata_q (0 for stores), clear counter, go to DONE, drop dm_req.
  - Counter reaches TIMEOUT-1 with dm_ready=0: rdata_q=0, timeout_err=1 for one cycle, go to DONE, drop dm_req.
- DONE: stall=0 and rdata_out=rdata_q, so MEM/WB captures the still-held instruction with valid data. Always return to IDLE next edge, so the same instruction does not retrigger.
- rdata_out = rdata_q in DONE, else 0.
- Store formatting, with off = addr[1:0]:
  - SB: be = 4'b0001<<off, wdata = {4{wdata[7:0]}}
  - SH: be = 4'b0011<<off, wdata = {2{wdata[15:0]}}
  - SW: be = 4'b1111
- Load formatting: select the byte or half at off from dm_rdata.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass through.

## Timing
- Minimum access (dm_ready high in the first ACCESS cycle): stall for 2 cycles (IDLE, ACCESS), DONE in cycle 3. Latency from request to MEM/WB capture is 3 edges.
- N-cycle memory (ready in the Nth ACCESS cycle): stall for N+1 cycles.
- dm_ready is ignored outside ACCESS.
- access_err and timeout_err are registered one-cycle pulses.
- Asynchronous reset mid-ACCESS: dm_req, stall and all outputs drop immediately; state goes to IDLE; a pending memory response is ignored.
- bubble is identical to stall every cycle.

## Test plan
- LW, addr=0x100, memory ready in the first ACCESS cycle with dm_rdata=0xDEADBEEF: stall high for 2 cycles; dm_addr=0x100, dm_be=1111, dm_we=0; DONE cycle rdata_out=0xDEADBEEF; back in IDLE after 1 cycle.
- LB, addr=0x103, dm_rdata=0x80FF_0000: rdata_out=0xFFFFFF80. LBU at the same address gives 0x00000080. LHU at 0x102 gives 0x000080FF.
- SH, addr=0x206, wdata=0x1234ABCD, 3-cycle memory: dm_be=1100, dm_wdata=0xABCDABCD, dm_we=1, stall for 4 cycles, rdata_out=0 in DONE.
- LW at addr=0x101: no dm_req, stall=0, access_err pulses once. Repeat with mem_read=mem_write=1, and with a load using funct3=011: same result.
- TIMEOUT=4 with dm_ready held low: dm_req high for exactly 4 cycles, then timeout_err pulses once, rdata_out=0 in DONE, FSM returns to IDLE.
- Assert reset_n low in the second ACCESS cycle: dm_req and stall go to 0 immediately. After release, a fresh SW completes normally.
